// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported unified memory between the fetch stage
// (instruction read at PCF) and the memory stage (load/store at ALUOutM) of a
// pipelined MIPS core. Every pipeline advance runs PICK -> [DATA] -> FETCH ->
// RELEASE. The data access of the older M-stage instruction always goes first.
// StallMem freezes the PC and all pipeline registers until RELEASE, where it
// drops for exactly one cycle so the pipeline advances on that edge.
//
// Parameters:
//   LATENCY     memory access time in clocks (1..15). Read data is valid and a
//               write commits in the last cycle of an access.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous, active-high
//   PCF         fetch address
//   MemReqM     M-stage instruction is a load or store
//   MemWriteM   M-stage access is a store (meaningful only with MemReqM)
//   ALUOutM     data address
//   WriteDataM  store data
//   MemRD       memory read data
//   MemEn       memory access active
//   MemWE       memory write strobe (one cycle per store)
//   MemAddr     memory address (0 when idle)
//   MemWD       memory write data (always WriteDataM)
//   InstrF      registered fetched instruction
//   ReadDataM   registered load data
//   StallMem    freeze pipeline
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] MemRD,
  output logic        MemEn,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  output logic [31:0] InstrF,
  output logic [31:0] ReadDataM,
  output logic        StallMem
);

  typedef enum logic [1:0] {
    PICK    = 2'd0,
    DATA    = 2'd1,
    FETCH   = 2'd2,
    RELEASE = 2'd3
  } stateType;

  localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

  stateType   state;
  stateType   stateNext;
  logic [3:0] cnt;
  logic [3:0] cntNext;
  logic       lastCycle;

  assign lastCycle = (cnt == LastCnt);
  assign MemWD     = WriteDataM;

  // State register and captured read data. Reset wins over every transition,
  // so an access interrupted by reset neither captures nor commits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PICK;
      cnt       <= '0;
      InstrF    <= '0;
      ReadDataM <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (state == FETCH && lastCycle) begin
        InstrF <= MemRD;
      end
      // Stores leave ReadDataM untouched.
      if (state == DATA && lastCycle && !MemWriteM) begin
        ReadDataM <= MemRD;
      end
    end
  end

  // Next-state and memory-side outputs, all combinational from state, cnt
  // and the (stall-frozen) pipeline inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    stateNext = state;
    cntNext   = cnt;
    MemEn     = 1'b0;
    MemWE     = 1'b0;
    MemAddr   = '0;
    StallMem  = 1'b1;

    case (state)
      PICK: begin
        // MemReqM comes straight from the M-stage register updated on the
        // previous edge, so it is already stable here.
        stateNext = MemReqM ? DATA : FETCH;
        cntNext   = '0;
      end

      DATA: begin
        MemEn   = 1'b1;
        MemAddr = ALUOutM;
        if (lastCycle) begin
          MemWE     = MemWriteM;
          stateNext = FETCH;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end

      FETCH: begin
        MemEn   = 1'b1;
        MemAddr = PCF;
        if (lastCycle) begin
          stateNext = RELEASE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 4'd1;
        end
      end

      RELEASE: begin
        StallMem  = 1'b0;
        stateNext = PICK;
        cntNext   = '0;
      end

      default: begin
        stateNext = PICK;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiter instances (LATENCY=2 and LATENCY=1) share one set of pipeline
// inputs and one memory model; whichever is not under test is held in reset.
// The memory model returns real data only in the LATENCY-th consecutive cycle
// of an access at a stable address, and a marker value otherwise.
// Directed stimulus pushes expected advances and stores into queues; a
// monitor pops and compares on every RELEASE cycle and every MemWE pulse.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset1 = 1'b1;
  logic        reset2 = 1'b1;
  logic        sel = 1'b0;         // 0: LATENCY=2 instance, 1: LATENCY=1
  logic [31:0] PCF = '0;
  logic        MemReqM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] MemRD;

  logic        memEn1, memWE1, stall1;
  logic        memEn2, memWE2, stall2;
  logic [31:0] memAddr1, memWD1, instr1, rdata1;
  logic [31:0] memAddr2, memWD2, instr2, rdata2;

  logic        MemEn, MemWE, StallMem, actRst;
  logic [31:0] MemAddr, MemWD, InstrF, ReadDataM;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .PCF(PCF), .MemReqM(MemReqM),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .MemRD(MemRD), .MemEn(memEn1), .MemWE(memWE1), .MemAddr(memAddr1),
    .MemWD(memWD1), .InstrF(instr1), .ReadDataM(rdata1), .StallMem(stall1)
  );

  mem_arbiter #(.LATENCY(2)) dut2 (
    .clk(clk), .reset(reset2), .PCF(PCF), .MemReqM(MemReqM),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .MemRD(MemRD), .MemEn(memEn2), .MemWE(memWE2), .MemAddr(memAddr2),
    .MemWD(memWD2), .InstrF(instr2), .ReadDataM(rdata2), .StallMem(stall2)
  );

  assign MemEn     = sel ? memEn1   : memEn2;
  assign MemWE     = sel ? memWE1   : memWE2;
  assign MemAddr   = sel ? memAddr1 : memAddr2;
  assign MemWD     = sel ? memWD1   : memWD2;
  assign InstrF    = sel ? instr1   : instr2;
  assign ReadDataM = sel ? rdata1   : rdata2;
  assign StallMem  = sel ? stall1   : stall2;
  assign actRst    = sel ? reset1   : reset2;

  // ---------------------------------------------------------------- memory
  function automatic logic [31:0] memLookup(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  logic        prevEn = 1'b0;
  logic [31:0] prevAddr = '0;
  int          runLen = 0;
  int          curRun;
  int          lat;

  assign lat = sel ? 1 : 2;

  always_comb begin
    curRun = 0;
    if (MemEn) curRun = (prevEn && MemAddr == prevAddr) ? runLen + 1 : 1;
    MemRD = (curRun == lat) ? memLookup(MemAddr) : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    prevEn   <= MemEn;
    prevAddr <= MemAddr;
    runLen   <= curRun;
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rdata;
    int          period;
  } advExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } stExp_t;

  advExp_t expQ[$];
  stExp_t  stQ[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  int cyc = 0;

  always @(negedge clk) begin
    if (actRst) begin
      cyc = 0;
    end else begin
      cyc++;
      if (MemWE) begin
        if (stQ.size() == 0) begin
          check("unexpected_memwe", 32'(MemWE), 32'd0);
        end else begin
          stExp_t s;
          s = stQ.pop_front();
          check("store_addr", MemAddr, s.addr);
          check("store_wd", MemWD, s.wd);
          check("store_en", 32'(MemEn), 32'd1);
        end
      end
      if (!StallMem) begin
        if (expQ.size() == 0) begin
          check("unexpected_release", 32'(StallMem), 32'd1);
        end else begin
          advExp_t e;
          e = expQ.pop_front();
          check("instr", InstrF, e.instr);
          check("rdata", ReadDataM, e.rdata);
          check("period", 32'(cyc), 32'(e.period));
          check("release_idle", {MemEn, MemWE, MemAddr != 32'h0}, 3'b000);
        end
        cyc = 0;
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic drive(input logic req, input logic wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    MemReqM    = req;
    MemWriteM  = wr;
    ALUOutM    = alu;
    WriteDataM = wd;
    PCF        = pc;
  endtask

  task automatic expectAdv(input logic [31:0] instr, input logic [31:0] rdata,
                           input int period);
    advExp_t e;
    e.instr  = instr;
    e.rdata  = rdata;
    e.period = period;
    expQ.push_back(e);
  endtask

  task automatic expectStore(input logic [31:0] addr, input logic [31:0] wd);
    stExp_t s;
    s.addr = addr;
    s.wd   = wd;
    stQ.push_back(s);
  endtask

  // Waits for the RELEASE cycle, then steps to #1 after the advancing edge,
  // where the DUT sits in PICK and new inputs may be applied.
  task automatic waitRelease();
    logic seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (!StallMem) seen = 1'b1;
    end
    check("release_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    check("stall_after_release", 32'(StallMem), 32'd1);
  endtask

  task automatic advance(input logic req, input logic wr, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] rdata,
                         input int period);
    drive(req, wr, alu, wd, pc);
    expectAdv(instr, rdata, period);
    if (req && wr) expectStore(alu, wd);
    waitRelease();
  endtask

  initial begin
    logic [31:0] lastRd;

    // Reset held 3 cycles with a pending load.
    drive(1'b1, 1'b0, 32'h100, 32'h0, 32'h44);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_stall", 32'(StallMem), 32'd1);
      check("rst_en", 32'(MemEn), 32'd0);
      check("rst_we", 32'(MemWE), 32'd0);
      check("rst_instr", InstrF, 32'h0);
      check("rst_rdata", ReadDataM, 32'h0);
    end
    reset2 = 1'b0;
    expectAdv(32'hC0DE_0044, 32'hDEAD_BEEF, 6);
    check("pick_idle", {MemEn, MemAddr != 32'h0}, 2'b00);
    @(posedge clk);
    #1;
    check("data_en", 32'(MemEn), 32'd1);
    check("data_addr", MemAddr, 32'h100);
    waitRelease();

    // LATENCY=2: no-op fetch, store, load.
    advance(1'b0, 1'b0, 32'h0,   32'h0,    32'h40, 32'h2008_0005, 32'hDEAD_BEEF, 4);
    advance(1'b1, 1'b1, 32'h104, 32'h1234, 32'h48, 32'hC0DE_0048, 32'hDEAD_BEEF, 6);
    advance(1'b1, 1'b0, 32'h108, 32'h0,    32'h4C, 32'hC0DE_004C, 32'hC0DE_0108, 6);

    // Reset during the first DATA cycle of a store: no write, no capture.
    drive(1'b1, 1'b1, 32'h10C, 32'h5555, 32'h50);
    @(posedge clk);
    #1;
    check("abort_data_addr", MemAddr, 32'h10C);
    reset2 = 1'b1;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    check("abort_pick", {MemEn, MemWE, StallMem}, 3'b001);
    check("abort_instr", InstrF, 32'h0);
    check("abort_rdata", ReadDataM, 32'h0);
    advance(1'b0, 1'b0, 32'h0, 32'h0, 32'h54, 32'hC0DE_0054, 32'h0, 4);

    // LATENCY=1: alternating load / no-op, with one store in the mix.
    sel    = 1'b1;
    reset2 = 1'b1;
    reset1 = 1'b0;
    lastRd = 32'h0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] pc, alu;
      pc  = 32'h80 + 32'(4 * i);
      alu = 32'h200 + 32'(4 * i);
      if (i == 4) begin
        advance(1'b1, 1'b1, alu, 32'hABCD, pc, 32'hC0DE_0000 | pc, lastRd, 4);
      end else if (i % 2 == 0) begin
        lastRd = 32'hC0DE_0000 | alu;
        advance(1'b1, 1'b0, alu, 32'h0, pc, 32'hC0DE_0000 | pc, lastRd, 4);
      end else begin
        advance(1'b0, 1'b0, 32'h0, 32'h0, pc, 32'hC0DE_0000 | pc, lastRd, 3);
      end
    end

    repeat (2) @(posedge clk);
    check("adv_queue_empty", 32'(expQ.size()), 32'd0);
    check("store_queue_empty", 32'(stQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares one single-ported unified memory between the fetch stage (instruction read at PCF) and the memory stage (load/store at ALUOutM) of the pipelined MIPS core. Each pipeline advance is split into a data access (only if the M-stage instruction needs memory) followed by an instruction fetch. The global stall StallMem is held high until both accesses complete. StallMem is ORed externally with the hazard unit's StallF/StallD and also freezes the E, M and W registers; the arbiter is unaware of hazard-unit stalls and flushes.

## Interface
Parameters:
- LATENCY, 2, memory access time in clocks (legal 1..15); read data valid and write committed in the last cycle of an access

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- PCF  in  32  fetch address
- MemReqM  in  1  M-stage instruction is a load or store
- MemWriteM  in  1  M-stage access is a store (valid only with MemReqM)
- ALUOutM  in  32  data address
- WriteDataM  in  32  store data
- MemRD  in  32  memory read data
- MemEn  out  1  memory access active
- MemWE  out  1  memory write strobe
- MemAddr  out  32  memory address
- MemWD  out  32  memory write data
- InstrF  out  32  registered fetched instruction
- ReadDataM  out  32  registered load data
- StallMem  out  1  freeze pipeline (PC and all pipeline registers)

## Operation
- States: PICK, DATA, FETCH, RELEASE. Cycle counter cnt is 4 bits and is cleared on every state change.
- PICK (1 cycle): no access. Samples MemReqM, which is stable from the pipeline registers updated on the previous edge.
  - MemReqM=1: go to DATA.
  - Otherwise: go to FETCH.
- DATA: MemEn=1, MemAddr=ALUOutM.
  - If cnt<LATENCY-1: cnt++.
  - If cnt==LATENCY-1: go to FETCH.
  - In the last cycle: a store asserts MemWE; a load captures MemRD into ReadDataM.
- FETCH: MemEn=1, MemAddr=PCF.
  - In the last cycle (cnt==LATENCY-1): capture MemRD into InstrF and go to RELEASE.
- RELEASE (1 cycle): StallMem=0, so the pipeline advances on this edge. Next state is PICK.
- StallMem=1 in PICK, DATA and FETCH.
- MemWE = DATA & MemWriteM & (cnt==LATENCY-1). It is exactly one cycle per store and never asserted outside DATA.
- MemAddr=0 in PICK and RELEASE. MemWD=WriteDataM at all times.
- ReadDataM is unchanged by stores and by cycles with no data access. InstrF is unchanged outside the last FETCH cycle.
- Data access always precedes fetch: the older instruction has priority.
- Inputs are held constant by the stall for the whole access. The arbiter does not re-check them mid-access.

## Timing
- Reset values (state after any clock edge with reset=1):
  - state=PICK, cnt=0, InstrF=0 (nop), ReadDataM=0.
  - Hence StallMem=1, MemEn=0, MemWE=0.
- Reset dominates all transitions. Reset asserted mid-DATA or mid-FETCH aborts the access:
  - no MemWE pulse if reset arrives before the last DATA cycle;
  - no register capture.
- Clocks per pipeline advance (PICK + DATA + FETCH + RELEASE):
  - no memory op: LATENCY+2;
  - load or store: 2·LATENCY+2.
- StallMem is low for exactly one cycle per advance, never two consecutive cycles.
- Captured InstrF and ReadDataM are valid from the cycle after capture (RELEASE for InstrF) until the next capture.
- With LATENCY=1, DATA and FETCH each last one cycle: 3 clocks per advance with no op, 4 with a memory op.
- MemEn, MemWE, MemAddr and StallMem are combinational from state, cnt and inputs, with no output registers.

## Test plan
- Reset: hold reset 3 cycles with MemReqM=1 → every cycle StallMem=1, MemEn=0, MemWE=0, InstrF=0, ReadDataM=0. First post-reset cycle is PICK (MemEn=0), followed by DATA.
- No-op fetch (LATENCY=2, MemReqM=0, PCF=0x40, MemRD=0x20080005 in the second FETCH cycle) → MemAddr=0x40 for 2 cycles, InstrF=0x20080005 in RELEASE, StallMem period 4 with one low cycle.
- Load (MemReqM=1, MemWriteM=0, ALUOutM=0x100, MemRD=0xDEADBEEF in the second DATA cycle) → MemAddr 0x100,0x100,PCF,PCF; ReadDataM=0xDEADBEEF; period 6; MemWE never high.
- Store (MemWriteM=1, ALUOutM=0x104, WriteDataM=0x1234, prior ReadDataM=0xDEADBEEF) → MemWE high only in the second DATA cycle with MemAddr=0x104, MemWD=0x1234; ReadDataM stays 0xDEADBEEF.
- Reset mid-store: assert reset in the first DATA cycle → MemWE never pulses, next state PICK, InstrF=0.
- LATENCY=1 back-to-back alternating load/no-op for 10 advances → periods alternate 4/3, one StallMem low cycle each.
